// File: rtl/uart_tx_arb_ctrl.sv
// uart_tx_arb_ctrl
//   Two-requester UART transmit controller. Picks one requester per frame
//   (round-robin when both ask), drives the shared baud tick generator
//   enable, and serialises start / 8 data (LSB first) / optional parity /
//   stop bits onto the line. All line-side outputs are registered.
//
// Ports
//   clk_i         system clock
//   rst_ni        asynchronous reset, active low
//   req_valid_i   per-requester frame request (bit n = requester n)
//   req_data0_i   byte of requester 0, held stable until accepted
//   req_data1_i   byte of requester 1, held stable until accepted
//   req_ready_o   one-cycle accept pulse; the byte is captured that cycle
//   bps_en_o      baud tick generator enable (its counter clears while low)
//   bps_clk_i     one-cycle bit-period tick from the baud tick generator
//   txd_o         serial line, idle high
//   busy_o        frame in progress (START through final stop tick)
//   grant_id_o    requester owning the current / last frame
//
// State table
//   state    | meaning
//   S_IDLE   | line idle, waiting for any request
//   S_LOAD   | one cycle: accept pulse, capture byte and parity
//   S_START  | start bit (txd=0)
//   S_DATA   | 8 data bits, LSB first
//   S_PARITY | parity bit (only when PARITY_EN=1)
//   S_STOP   | STOP_BITS stop bits (txd=1)
module uart_tx_arb_ctrl #(
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_valid_i,
    input  logic [7:0] req_data0_i,
    input  logic [7:0] req_data1_i,
    output logic [1:0] req_ready_o,
    output logic       bps_en_o,
    input  logic       bps_clk_i,
    output logic       txd_o,
    output logic       busy_o,
    output logic       grant_id_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_e;

    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic       PAR_ODD   = (PARITY_ODD != 0);

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       sel_q, sel_d;
    logic       par_q;
    logic       grant_id_q, last_grant_q;
    logic       txd_q, txd_d;
    logic       bps_en_q, bps_en_d;
    logic       busy_q, busy_d;

    logic       tick;
    logic       arb_pick;
    logic [7:0] data_sel;

    // Ticks that arrive while the generator is disabled are stale; drop them.
    assign tick     = bps_clk_i & bps_en_q;
    // Both asking: the one not served last time wins.
    assign arb_pick = (&req_valid_i) ? ~last_grant_q : req_valid_i[1];
    assign data_sel = sel_q ? req_data1_i : req_data0_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        sel_d     = sel_q;
        case (state_q)
            S_IDLE: begin
                if (|req_valid_i) begin
                    state_d = S_LOAD;
                    sel_d   = arb_pick;
                end
            end
            S_LOAD: begin
                state_d   = S_START;
                shift_d   = data_sel;
                bit_cnt_d = 3'd0;
            end
            S_START: begin
                if (tick) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
                        state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d   = S_STOP;
                    bit_cnt_d = 3'd0;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = 3'd0;
                        // Back-to-back frames skip IDLE so no extra idle bit appears.
                        if (|req_valid_i) begin
                            state_d = S_LOAD;
                            sel_d   = arb_pick;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: line-side values are decoded from the next state and registered,
    // so txd/bps_en/busy move exactly on state transitions.
    always_comb begin
        req_ready_o = 2'b00;
        if (state_q == S_LOAD) begin
            req_ready_o = sel_q ? 2'b10 : 2'b01;
        end
        txd_d = 1'b1;
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = par_q;
            default:  txd_d = 1'b1;
        endcase
        bps_en_d = (state_d == S_START) || (state_d == S_DATA) ||
                   (state_d == S_PARITY) || (state_d == S_STOP);
        busy_d   = bps_en_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            sel_q        <= 1'b0;
            par_q        <= 1'b0;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
            txd_q        <= 1'b1;
            bps_en_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            sel_q     <= sel_d;
            txd_q     <= txd_d;
            bps_en_q  <= bps_en_d;
            busy_q    <= busy_d;
            if (state_q == S_LOAD) begin
                par_q        <= (^data_sel) ^ PAR_ODD;
                grant_id_q   <= sel_q;
                last_grant_q <= sel_q;
            end
        end
    end

    assign txd_o      = txd_q;
    assign bps_en_o   = bps_en_q;
    assign busy_o     = busy_q;
    assign grant_id_o = grant_id_q;

endmodule
